// File: rtl/ewma_jam_sequencer.sv
// ewma_jam_sequencer
// Sequences the EWMA jamming-detection datapath: accepts RSSI samples,
// maintains the exponentially weighted average, strobes the threshold
// decision block after warm-up and debounces its alert into jam_detected
// plus a one-cycle interrupt.
module ewma_jam_sequencer #(
    parameter int unsigned ALPHA_SHIFT = 3,
    parameter int unsigned WARMUP      = 8,
    parameter int unsigned CONFIRM     = 4,
    parameter int unsigned CLEAR_N     = 4
) (
    input  logic               clk_h,
    input  logic               rst_h,
    input  logic               enable,
    input  logic               clear,
    input  logic               rssi_valid,
    input  logic signed [31:0] rssi_data,
    output logic               rssi_ready,
    output logic signed [31:0] ewma_rssi,
    output logic               EnableDecision,
    input  logic               Alert_Jamming,
    output logic               jam_detected,
    output logic               jam_irq,
    output logic [15:0]        sample_count,
    output logic [15:0]        alert_count
);

    localparam logic [15:0] WARMUP_C  = 16'(WARMUP);
    localparam logic [15:0] CONFIRM_C = 16'(CONFIRM);
    localparam logic [15:0] CLEAR_C   = 16'(CLEAR_N);

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DECIDE,
        SAMPLE
    } state_t;

    state_t state, state_nxt;

    logic               armed;
    logic               seeded;
    logic               irq_q;
    logic signed [31:0] sample_q;
    logic signed [31:0] ewma_q;
    logic [15:0]        consec_alert;
    logic [15:0]        consec_clear;

    logic               accept;
    logic signed [32:0] diff;
    logic signed [31:0] ewma_upd;
    logic [15:0]        alert_inc;
    logic [15:0]        clear_inc;

    // armed is low while in reset so rssi_ready reads 0 until the first
    // clock edge after reset release, even with enable already high.
    assign rssi_ready     = armed && (state == IDLE) && enable && !clear;
    assign accept         = rssi_valid && rssi_ready;
    assign EnableDecision = (state == DECIDE) && !clear;
    assign jam_irq        = irq_q && !clear;
    assign ewma_rssi      = ewma_q;

    // 33-bit difference keeps the sign when sample and average are far apart;
    // the new average lies between old average and sample, so truncation is safe.
    assign diff      = $signed({sample_q[31], sample_q}) - $signed({ewma_q[31], ewma_q});
    assign ewma_upd  = 32'($signed({ewma_q[31], ewma_q}) + (diff >>> ALPHA_SHIFT));
    assign alert_inc = (consec_alert >= CONFIRM_C) ? CONFIRM_C : consec_alert + 16'd1;
    assign clear_inc = (consec_clear >= CLEAR_C) ? CLEAR_C : consec_clear + 16'd1;

    // State register
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = UPDATE;
            UPDATE:  state_nxt = (sample_count >= WARMUP_C) ? DECIDE : IDLE;
            DECIDE:  state_nxt = SAMPLE;
            SAMPLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    // Datapath: sample latch, EWMA update, counters and debounce
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            armed        <= 1'b0;
            seeded       <= 1'b0;
            irq_q        <= 1'b0;
            sample_q     <= '0;
            ewma_q       <= '0;
            consec_alert <= '0;
            consec_clear <= '0;
            sample_count <= '0;
            alert_count  <= '0;
            jam_detected <= 1'b0;
        end else begin
            armed <= 1'b1;
            irq_q <= 1'b0;
            if (clear) begin
                seeded       <= 1'b0;
                ewma_q       <= '0;
                consec_alert <= '0;
                consec_clear <= '0;
                sample_count <= '0;
                alert_count  <= '0;
                jam_detected <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            sample_q <= rssi_data;
                            if (sample_count != '1) sample_count <= sample_count + 16'd1;
                        end
                    end
                    UPDATE: begin
                        seeded <= 1'b1;
                        ewma_q <= seeded ? ewma_upd : sample_q;
                    end
                    SAMPLE: begin
                        if (Alert_Jamming) begin
                            consec_alert <= alert_inc;
                            consec_clear <= '0;
                            if (alert_count != '1) alert_count <= alert_count + 16'd1;
                            if ((alert_inc == CONFIRM_C) && !jam_detected) begin
                                jam_detected <= 1'b1;
                                irq_q        <= 1'b1;
                            end
                        end else begin
                            consec_clear <= clear_inc;
                            consec_alert <= '0;
                            if ((clear_inc == CLEAR_C) && jam_detected) begin
                                jam_detected <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
